dds_tune_ctrl: RTL and testbench

- Consumes the single-cycle, edge-detected button pulses produced by the button front-end stage.
- Keeps the DDS control state: phase tuning word, waveform select, and frequency step index.
- Saturates the tuning word within limits and applies a post-command lockout to absorb residual bounce.
- Emits a one-cycle update strobe to the phase accumulator/waveform LUT stage downstream.

---
 rtl/dds_tune_ctrl.sv | 144 ++++++++++++++
 tb/tb_dds_tune_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dds_tune_ctrl.sv
// DDS tuning controller: turns edge-detected button pulses into tuning word,
// waveform select and step index updates, with saturation and post-command lockout.
`timescale 1ns/1ps
module dds_tune_ctrl #(
  parameter int unsigned     TW_W        = 32,
  parameter logic [TW_W-1:0] TW_RESET    = 32'd42950,
  parameter logic [TW_W-1:0] TW_MIN      = 32'd1,
  parameter logic [TW_W-1:0] TW_MAX      = 32'h7FFF_FFFF,
  parameter int unsigned     NUM_STEPS   = 8,
  parameter int unsigned     STEP_LSB    = 0,
  parameter int unsigned     STEP_STRIDE = 3,
  parameter int unsigned     LOCK_CYC    = 16,
  localparam int unsigned    SIW         = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic            iBtnUp,
  input  logic            iBtnDown,
  input  logic            iBtnStep,
  input  logic            iBtnWave,
  output logic [TW_W-1:0] oTuneWord,
  output logic [1:0]      oWaveSel,
  output logic [SIW-1:0]  oStepIdx,
  output logic            oUpdate
);

  localparam int unsigned LCW = (LOCK_CYC > 0) ? $clog2(LOCK_CYC + 1) : 1;

  if (!((TW_MIN <= TW_RESET) && (TW_RESET <= TW_MAX))) begin : g_bad_reset_word
    $error("dds_tune_ctrl: TW_RESET must lie within [TW_MIN, TW_MAX]");
  end
  if ((STEP_LSB + STEP_STRIDE * (NUM_STEPS - 1)) >= TW_W) begin : g_bad_step_range
    $error("dds_tune_ctrl: largest step exceeds the tuning word width");
  end

  typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_r;
  logic [LCW-1:0]  cnt_r;
  logic [TW_W-1:0] tw_r;
  logic [1:0]      wave_r;
  logic [SIW-1:0]  step_r;
  logic            update_r;

  logic [TW_W:0]   step_s;
  logic [TW_W:0]   sum_s;
  logic [TW_W:0]   floor_s;
  logic [TW_W-1:0] up_val_s;
  logic [TW_W-1:0] down_val_s;
  logic [TW_W-1:0] tw_next_s;
  logic [1:0]      wave_next_s;
  logic [SIW-1:0]  step_next_s;
  logic            tw_chg_s;
  logic            step_chg_s;
  logic            accept_s;
  logic            update_s;

  // Decoded step size for a given index, widened by one bit for overflow-safe compares.
  function automatic logic [TW_W:0] step_of(input logic [SIW-1:0] idx);
    logic [TW_W:0] s;
    s = '0;
    for (int i = 0; i < int'(NUM_STEPS); i++) begin
      s = (idx == i[SIW-1:0]) ? ({{TW_W{1'b0}}, 1'b1} << (STEP_LSB + STEP_STRIDE * i)) : s;
    end
    return s;
  endfunction

  // Candidate next values; Up/Down use the index before any step advance.
  always_comb begin
    step_s      = step_of(step_r);
    sum_s       = {1'b0, tw_r} + step_s;
    floor_s     = {1'b0, TW_MIN} + step_s;
    up_val_s    = (sum_s > {1'b0, TW_MAX}) ? TW_MAX : sum_s[TW_W-1:0];
    down_val_s  = ({1'b0, tw_r} < floor_s) ? TW_MIN : (tw_r - step_s[TW_W-1:0]);
    tw_next_s   = tw_r;
    if (iBtnUp && !iBtnDown) begin
      tw_next_s = up_val_s;
    end else if (iBtnDown && !iBtnUp) begin
      tw_next_s = down_val_s;
    end else begin
      tw_next_s = tw_r;
    end
    wave_next_s = iBtnWave ? (wave_r + 2'd1) : wave_r;
    step_next_s = step_r;
    if (iBtnStep) begin
      step_next_s = (step_r == SIW'(NUM_STEPS - 1)) ? '0 : (step_r + SIW'(1));
    end else begin
      step_next_s = step_r;
    end
    tw_chg_s    = (tw_next_s != tw_r);
    step_chg_s  = (step_next_s != step_r);
    update_s    = tw_chg_s | iBtnWave;
    accept_s    = update_s | step_chg_s;
  end

  // Control FSM: commands applied only in IDLE, LOCK swallows pulses for LOCK_CYC edges.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      tw_r     <= TW_RESET;
      wave_r   <= 2'd0;
      step_r   <= '0;
      update_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          tw_r     <= tw_next_s;
          wave_r   <= wave_next_s;
          step_r   <= step_next_s;
          update_r <= update_s;
          if (accept_s && (LOCK_CYC > 0)) begin
            state_r <= LOCK;
            cnt_r   <= LCW'(LOCK_CYC);
          end else begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end
        end
        LOCK: begin
          update_r <= 1'b0;
          if (cnt_r <= LCW'(1)) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else begin
            state_r <= LOCK;
            cnt_r   <= cnt_r - LCW'(1);
          end
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= '0;
          update_r <= 1'b0;
        end
      endcase
    end
  end

  assign oTuneWord = tw_r;
  assign oWaveSel  = wave_r;
  assign oStepIdx  = step_r;
  assign oUpdate   = update_r;

endmodule

// File: tb/tb_dds_tune_ctrl.sv
// Table-driven bench for dds_tune_ctrl: per-edge expectations queued at drive time,
// popped and compared 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_dds_tune_ctrl;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        iBtnUp = 1'b0;
  logic        iBtnDown = 1'b0;
  logic        iBtnStep = 1'b0;
  logic        iBtnWave = 1'b0;
  logic [15:0] oTuneWord;
  logic [1:0]  oWaveSel;
  logic [1:0]  oStepIdx;
  logic        oUpdate;

  int checks = 0;
  int errors = 0;

  dds_tune_ctrl #(
    .TW_W(16), .TW_RESET(16'd100), .TW_MIN(16'd1), .TW_MAX(16'd1000),
    .NUM_STEPS(4), .STEP_LSB(0), .STEP_STRIDE(2), .LOCK_CYC(3)
  ) dut (
    .CLK(CLK), .RESETn(RESETn),
    .iBtnUp(iBtnUp), .iBtnDown(iBtnDown), .iBtnStep(iBtnStep), .iBtnWave(iBtnWave),
    .oTuneWord(oTuneWord), .oWaveSel(oWaveSel), .oStepIdx(oStepIdx), .oUpdate(oUpdate)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        up, down, step, wave;
    int          gap;
    logic [15:0] tw;
    logic [1:0]  ws;
    logic [1:0]  si;
    logic        upd;
  } vec_t;

  typedef struct {
    logic [15:0] tw;
    logic [1:0]  ws;
    logic [1:0]  si;
    logic        upd;
    string       tag;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  function automatic void add(input logic u, input logic d, input logic s, input logic w,
                              input int gap, input int tw, input int ws, input int si,
                              input logic upd);
    vec_t v;
    v.up = u; v.down = d; v.step = s; v.wave = w; v.gap = gap;
    v.tw = 16'(tw); v.ws = 2'(ws); v.si = 2'(si); v.upd = upd;
    tbl.push_back(v);
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      cmp({e.tag, ".tw"},   32'(oTuneWord), 32'(e.tw));
      cmp({e.tag, ".wave"}, 32'(oWaveSel),  32'(e.ws));
      cmp({e.tag, ".step"}, 32'(oStepIdx),  32'(e.si));
      cmp({e.tag, ".upd"},  32'(oUpdate),   32'(e.upd));
    end
  endtask

  task automatic cycle(input logic u, input logic d, input logic s, input logic w,
                       input exp_t e);
    iBtnUp = u; iBtnDown = d; iBtnStep = s; iBtnWave = w;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    iBtnUp = 1'b0; iBtnDown = 1'b0; iBtnStep = 1'b0; iBtnWave = 1'b0;
    pop_check();
  endtask

  function automatic exp_t mk(input int tw, input int ws, input int si, input logic upd,
                              input string tag);
    exp_t e;
    e.tw = 16'(tw); e.ws = 2'(ws); e.si = 2'(si); e.upd = upd; e.tag = tag;
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    vec_t v;

    // reset values while held in reset
    repeat (2) @(posedge CLK);
    #1;
    exp_q.push_back(mk(100, 0, 0, 1'b0, "reset"));
    pop_check();
    @(negedge CLK);
    RESETn = 1'b1;

    // lockout window: N accepted, N+2 ignored, N+4 accepted
    add(1'b1, 1'b0, 1'b0, 1'b0, 1, 101, 0, 0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1, 101, 0, 0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 3, 102, 0, 0, 1'b1);
    // step index to 3 with no strobe
    add(1'b0, 1'b0, 1'b1, 1'b0, 4, 102, 0, 1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 4, 102, 0, 2, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 4, 102, 0, 3, 1'b0);
    // ramp up by 64 to 998, then clamp at 1000
    for (int k = 1; k <= 14; k++) add(1'b1, 1'b0, 1'b0, 1'b0, 3, 102 + 64 * k, 0, 3, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 3, 1000, 0, 3, 1'b1);
    // saturated no-ops start no lockout: the following Down lands on the next edge
    add(1'b1, 1'b0, 1'b0, 1'b0, 0, 1000, 0, 3, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 0, 1000, 0, 3, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 3, 936, 0, 3, 1'b1);
    // ramp down to 40, then clamp at 1, then saturated no-op
    for (int k = 1; k <= 14; k++) add(1'b0, 1'b1, 1'b0, 1'b0, 3, 936 - 64 * k, 0, 3, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 3, 1, 0, 3, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 0, 3, 1'b0);
    // step index wraps 3 -> 0
    add(1'b0, 1'b0, 1'b1, 1'b0, 3, 1, 0, 0, 1'b0);
    // Up+Down cancel, Wave applies; three locked Wave pulses dropped
    add(1'b1, 1'b1, 1'b0, 1'b1, 0, 1, 1, 0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1, 0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1, 0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1, 0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 4, 1, 2, 0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 4, 1, 3, 0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 4, 1, 0, 0, 1'b1);
    // Up+Step: Up uses pre-increment step (1), then step 4 applies
    add(1'b1, 1'b0, 1'b1, 1'b0, 3, 2, 0, 1, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 3, 6, 0, 1, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      cycle(v.up, v.down, v.step, v.wave, mk(v.tw, v.ws, v.si, v.upd, $sformatf("row%0d", i)));
      for (int g = 0; g < v.gap; g++) begin
        cycle(1'b0, 1'b0, 1'b0, 1'b0, mk(v.tw, v.ws, v.si, 1'b0, $sformatf("row%0d_idle%0d", i, g)));
      end
    end

    // asynchronous reset one cycle into a lockout
    cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(10, 0, 1, 1'b1, "lk_up"));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, mk(10, 0, 1, 1'b0, "lk_hold"));
    #2;
    RESETn = 1'b0;
    #1;
    exp_q.push_back(mk(100, 0, 0, 1'b0, "rst_async"));
    pop_check();
    @(negedge CLK);
    RESETn = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(101, 0, 0, 1'b1, "post_rst_up"));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, mk(101, 0, 0, 1'b0, "post_rst_idle"));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
